muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative radix-2 multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Takes the two register-file read operands and produces a 2*WIDTH {hi,lo} word that is written into the special HI/LO register pair through the 64-bit result path.
- Asserts busy so the controller can stall the PC and hold the instruction until the result is available.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  input  WIDTH  multiplicand / dividend.
- srcb  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse; result is valid from this cycle on.
- result  output  2*WIDTH  mul: {hi,lo} product; div: {remainder, quotient}.
- div_zero  output  1  high with done when a DIV/DIVU had srcb==0; held until the next accepted start.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, div_zero=0, result=0, counter=0. Reset mid-operation abandons the operation, and result stays 0.
- States and transitions:
  - IDLE -> CALC on a clk edge with start=1. At that edge: latch op; latch |srca| and |srcb| for signed ops (raw values for unsigned); record the result sign; counter=WIDTH; busy=1; div_zero cleared.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements. When counter reaches 1 and a step is taken -> FIX. This gives WIDTH cycles in CALC.
  - FIX, one cycle:
    - apply sign correction;
    - write result;
    - done=1 and busy=0 on the following cycle;
    - -> IDLE.
- Latency:
  - start is accepted at edge E0.
  - done is visible after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - busy is high after E0 through E(WIDTH+1), exclusive.
- done is exactly one cycle. result holds its value until the next FIX or reset.
- start while busy is ignored; there is no queueing. start asserted in the same cycle as done is accepted, because the state is IDLE in that cycle.
- Sign rules:
  - MULT: product is negated if the operand signs differ.
  - DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
  - The most negative value of srca and srcb is handled via a WIDTH+1-bit magnitude.
- Boundary cases:
  - DIV of 0x80000000 by 0xFFFFFFFF gives quotient 0x80000000, remainder 0, and no flag.
  - Divide by zero (DIV or DIVU) runs the full latency.
    - Quotient: all ones for DIVU. For DIV, all ones if srca>=0, else 1.
    - Remainder: srca.
    - div_zero=1.
- Operand inputs may change after E0 without effect.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined: in CALC for MULT/MULTU, if the remaining unshifted multiplier bits are all zero, the remaining shift is applied in one step and the state goes to FIX. Latency becomes variable, between 2 and WIDTH+1 cycles. Division is unchanged.
- When undefined: fixed WIDTH+1 latency for all ops, and no extra comparator logic.
- The bench checks result values under both settings. It checks latency only when the macro is undefined.

Decomposition:
- Package muldiv_pkg:
  - op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (IDLE, CALC, FIX);
  - localparam default WIDTH.
- Sub-module muldiv_signfix: combinational conditional two's-complement negate, used for the operand magnitudes and the final correction.
- Everything else lives in muldiv_unit.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> done 33 cycles after start, result=0xFFFFFFFF_FFFFFFEB, busy low on done.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE_00000001.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> result=0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
- DIVU 100/0 -> result=0x00000064_FFFFFFFF, div_zero=1. A following MULTU 2*3 clears div_zero and gives result=0x00000000_00000006.
- Start a DIVU, assert start again at cycle 5 with other operands -> second start ignored; the original result is produced at cycle 33. Then assert start in the done cycle -> accepted, and busy is high in the next cycle.
- Assert reset at cycle 10 of a MULT -> busy=0, done=0, result=0 immediately. No done pulse follows; the unit accepts start after reset deasserts.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Provides the operation encoding, FSM state encoding and the default operand width.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Operation encoding as presented on the op port
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate (combinational).
// Ports:
//   operand  N-bit value
//   negate   1 = return -operand, 0 = pass through
//   fixed_c  N-bit result
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int unsigned N = DEFAULT_WIDTH
) (
  input  logic [N-1:0] operand,
  input  logic         negate,
  output logic [N-1:0] fixed_c
);

  assign fixed_c = negate ? (~operand + N'(1)) : operand;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Works on operand magnitudes, then applies the sign correction in a final FIX
// cycle and writes the 2*WIDTH {hi,lo} word.
// Optional build macro: MULDIV_EARLY_OUT_EN -- multiplies finish as soon as the
// remaining multiplier bits are all zero (division latency unchanged).
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       request, sampled only while idle
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srca, srcb  multiplicand/dividend, multiplier/divisor
//   busy        operation in flight
//   done        one-cycle completion pulse
//   result      mul: {hi,lo} product; div: {remainder, quotient}
//   div_zero    divide by zero seen, valid from done until next accepted start
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = 2 * WIDTH;

  // Registered state
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [WIDTH-1:0] hi_q, hi_d;        // partial product high / running remainder
  logic [WIDTH-1:0] lo_q, lo_d;        // multiplier being shifted out / quotient
  logic [WIDTH:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_pend_q, dz_pend_d;
  logic             busy_d, done_d, div_zero_d;
  logic [RW-1:0]    result_d;

  // Input decode and operand magnitudes
  op_e              op_in_c;
  logic             in_signed_c, in_div_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH:0]   a_mag_c, b_mag_c;

  assign op_in_c     = op_e'(op);
  assign in_signed_c = op_is_signed(op_in_c);
  assign in_div_c    = op_is_div(op_in_c);
  assign a_neg_c     = in_signed_c & srca[WIDTH-1];
  assign b_neg_c     = in_signed_c & srcb[WIDTH-1];

  // WIDTH+1 bits so the most negative operand has a representable magnitude
  muldiv_signfix #(.N(WIDTH + 1)) u_abs_a (
    .operand ({a_neg_c, srca}),
    .negate  (a_neg_c),
    .fixed_c (a_mag_c)
  );

  muldiv_signfix #(.N(WIDTH + 1)) u_abs_b (
    .operand ({b_neg_c, srcb}),
    .negate  (b_neg_c),
    .fixed_c (b_mag_c)
  );

  // Final sign correction of product, remainder and quotient
  logic [RW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] rem_fix_c, quo_fix_c;

  muldiv_signfix #(.N(RW)) u_fix_prod (
    .operand ({hi_q, lo_q}),
    .negate  (neg_res_q),
    .fixed_c (prod_fix_c)
  );

  muldiv_signfix #(.N(WIDTH)) u_fix_rem (
    .operand (hi_q),
    .negate  (neg_rem_q),
    .fixed_c (rem_fix_c)
  );

  muldiv_signfix #(.N(WIDTH)) u_fix_quo (
    .operand (lo_q),
    .negate  (neg_res_q),
    .fixed_c (quo_fix_c)
  );

  // One shift-add multiply step
  logic [WIDTH:0] mul_sum_c;
  assign mul_sum_c = {1'b0, hi_q} + (lo_q[0] ? opnd_q : '0);

  // One restoring shift-subtract divide step
  logic [WIDTH:0] rem_sh_c;
  logic           rem_ge_c;
  assign rem_sh_c = {hi_q, lo_q[WIDTH-1]};
  assign rem_ge_c = (rem_sh_c >= opnd_q);

  logic is_div_q_c;
  assign is_div_q_c = op_is_div(op_q);

`ifdef MULDIV_EARLY_OUT_EN
  // counter_q multiplier bits remain unshifted at the bottom of lo_q
  localparam logic [WIDTH:0] ONE_W1 = (WIDTH + 1)'(1);
  logic [WIDTH-1:0] rem_mask_c;
  logic             eo_hit_c;
  logic [RW-1:0]    eo_prod_c;
  assign rem_mask_c = WIDTH'((ONE_W1 << counter_q) - ONE_W1);
  assign eo_hit_c   = !is_div_q_c && ((lo_q & rem_mask_c) == '0);
  assign eo_prod_c  = {hi_q, lo_q} >> counter_q;
`endif

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    counter_d  = counter_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_pend_d  = dz_pend_q;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = div_zero;
    result_d   = result;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          op_d       = op_in_c;
          counter_d  = CW'(WIDTH);
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          dz_pend_d  = in_div_c && (srcb == '0);
          neg_res_d  = a_neg_c ^ b_neg_c;
          neg_rem_d  = a_neg_c;
          hi_d       = '0;
          if (in_div_c) begin
            opnd_d = b_mag_c;
            lo_d   = a_mag_c[WIDTH-1:0];
          end else begin
            opnd_d = a_mag_c;
            lo_d   = b_mag_c[WIDTH-1:0];
          end
        end
      end

      CALC: begin
        counter_d = counter_q - CW'(1);
        if (counter_q == CW'(1)) begin
          state_d = FIX;
        end
        if (is_div_q_c) begin
          hi_d = rem_ge_c ? WIDTH'(rem_sh_c - opnd_q) : rem_sh_c[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], rem_ge_c};
        end else begin
          hi_d = mul_sum_c[WIDTH:1];
          lo_d = {mul_sum_c[0], lo_q[WIDTH-1:1]};
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (eo_hit_c) begin
          {hi_d, lo_d} = eo_prod_c;
          counter_d    = '0;
          state_d      = FIX;
        end
`endif
      end

      FIX: begin
        result_d   = is_div_q_c ? {rem_fix_c, quo_fix_c} : prod_fix_c;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        div_zero_d = dz_pend_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      counter_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      counter_q <= counter_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
      result    <= result_d;
    end
  end

endmodule
